// File: rtl/geo_dist_operand_prep.sv
// geo_dist_operand_prep
//   Operand preparation for the geo-distance signed multiplier (COEF_W x DELTA_W).
//   Takes two points as signed 32-bit binary angles (2^32 = 360 deg) and produces:
//     m_coef : cos(mean latitude), Q1.14, from a 16-entry table
//     m_dlat : (lat_b - lat_a) >>> SHIFT, saturated to DELTA_W signed
//     m_dlon : wrapped (lon_b - lon_a) >>> SHIFT, saturated to DELTA_W signed
//     m_sat  : either delta was clamped
//   Two-stage valid/ready pipeline, one transaction per cycle, 2-cycle latency.
//
// Ports
//   ap_clk, ap_rst_n        clock (rising edge), asynchronous active-low reset
//   s_valid / s_ready       input handshake; s_ready is combinational
//   lat_a, lon_a, lat_b, lon_b  input points
//   m_valid / m_ready       output handshake; payload held while stalled
//   m_coef, m_dlat, m_dlon, m_sat  registered multiplier operands and clamp flag
module geo_dist_operand_prep #(
    parameter int unsigned SHIFT   = 12,
    parameter int unsigned COEF_W  = 15,
    parameter int unsigned DELTA_W = 20
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [31:0]               lat_a,
    input  logic [31:0]               lon_a,
    input  logic [31:0]               lat_b,
    input  logic [31:0]               lon_b,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [COEF_W-1:0]         m_coef,
    output logic signed [DELTA_W-1:0] m_dlat,
    output logic signed [DELTA_W-1:0] m_dlon,
    output logic                      m_sat
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Returns {clamped, value}. Value fits when all bits above the target
    // sign bit replicate it; otherwise clamp toward the sign.
    function automatic logic [DELTA_W:0] sat_delta(input logic signed [32:0] v);
        logic [32-DELTA_W+1:0] upper;
        logic [DELTA_W-1:0]    val;
        logic                  clamp;
        upper = v[32:DELTA_W-1];
        clamp = !((&upper) || !(|upper));
        if (!clamp) begin
            val = v[DELTA_W-1:0];
        end else if (v[32]) begin
            val = {1'b1, {(DELTA_W-1){1'b0}}};
        end else begin
            val = {1'b0, {(DELTA_W-1){1'b1}}};
        end
        return {clamp, val};
    endfunction

    // cos((i + 0.5) * 90/16 deg) in Q1.14, capped at 16383.
    function automatic logic [COEF_W-1:0] cos_lut(input logic [3:0] idx);
        logic [COEF_W-1:0] c;
        case (idx)
            4'd0:    c = COEF_W'(16364);
            4'd1:    c = COEF_W'(16207);
            4'd2:    c = COEF_W'(15893);
            4'd3:    c = COEF_W'(15426);
            4'd4:    c = COEF_W'(14811);
            4'd5:    c = COEF_W'(14053);
            4'd6:    c = COEF_W'(13160);
            4'd7:    c = COEF_W'(12140);
            4'd8:    c = COEF_W'(11003);
            4'd9:    c = COEF_W'(9760);
            4'd10:   c = COEF_W'(8423);
            4'd11:   c = COEF_W'(7005);
            4'd12:   c = COEF_W'(5520);
            4'd13:   c = COEF_W'(3981);
            4'd14:   c = COEF_W'(2404);
            default: c = COEF_W'(804);
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic ld1, ld2;

    assign ld2     = !v2_q || m_ready;
    assign ld1     = !v1_q || ld2;
    assign s_ready = ld1;
    assign m_valid = v2_q;

    // ------------------------------------------------------------------
    // Stage 1: raw deltas and |mean latitude|
    // ------------------------------------------------------------------
    logic signed [32:0] dlat_q, dlat_d;
    logic [31:0]        dlon_q, dlon_d;
    logic [31:0]        mlat_q, mlat_d;

    logic signed [32:0] dlat_c;
    logic [31:0]        dlon_c;
    logic signed [31:0] lat_avg;
    logic [31:0]        mlat_c;

    always_comb begin
        dlat_c = $signed({lat_b[31], lat_b}) - $signed({lat_a[31], lat_a});
        // Modular subtraction gives the shortest way across +-180 deg.
        dlon_c = lon_b - lon_a;
        // floor((a + b) / 2) without a 33-bit sum.
        lat_avg = ($signed(lat_a) >>> 1) + ($signed(lat_b) >>> 1)
                + $signed({31'd0, lat_a[0] & lat_b[0]});
        // Negating -2^31 yields 2^31, correct when read as unsigned.
        mlat_c = lat_avg[31] ? (~lat_avg + 32'd1) : lat_avg;
    end

    always_comb begin
        v1_d   = v1_q;
        dlat_d = dlat_q;
        dlon_d = dlon_q;
        mlat_d = mlat_q;
        if (ld1) begin
            v1_d = s_valid;
            if (s_valid) begin
                dlat_d = dlat_c;
                dlon_d = dlon_c;
                mlat_d = mlat_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: scale, saturate, coefficient lookup
    // ------------------------------------------------------------------
    logic [COEF_W-1:0]         coef_q, coef_d;
    logic signed [DELTA_W-1:0] odlat_q, odlat_d;
    logic signed [DELTA_W-1:0] odlon_q, odlon_d;
    logic                      sat_q, sat_d;

    logic signed [32:0] dlat_sh;
    logic signed [32:0] dlon_sh;
    logic [DELTA_W:0]   dlat_s;
    logic [DELTA_W:0]   dlon_s;
    logic [COEF_W-1:0]  coef_c;

    always_comb begin
        dlat_sh = dlat_q >>> SHIFT;
        dlon_sh = $signed({dlon_q[31], dlon_q}) >>> SHIFT;
        dlat_s  = sat_delta(dlat_sh);
        dlon_s  = sat_delta(dlon_sh);
        // Mean latitude at or beyond the pole bound gives a zero coefficient.
        if (mlat_q[31] || mlat_q[30]) begin
            coef_c = '0;
        end else begin
            coef_c = cos_lut(mlat_q[29:26]);
        end
    end

    always_comb begin
        v2_d    = v2_q;
        coef_d  = coef_q;
        odlat_d = odlat_q;
        odlon_d = odlon_q;
        sat_d   = sat_q;
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                coef_d  = coef_c;
                odlat_d = dlat_s[DELTA_W-1:0];
                odlon_d = dlon_s[DELTA_W-1:0];
                sat_d   = dlat_s[DELTA_W] || dlon_s[DELTA_W];
            end
        end
    end

    // Only the top six magnitude bits select the coefficient.
    logic unused_mlat;
    assign unused_mlat = ^mlat_q[25:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            dlat_q  <= '0;
            dlon_q  <= '0;
            mlat_q  <= '0;
            coef_q  <= '0;
            odlat_q <= '0;
            odlon_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            dlat_q  <= dlat_d;
            dlon_q  <= dlon_d;
            mlat_q  <= mlat_d;
            coef_q  <= coef_d;
            odlat_q <= odlat_d;
            odlon_q <= odlon_d;
            sat_q   <= sat_d;
        end
    end

    assign m_coef = coef_q;
    assign m_dlat = odlat_q;
    assign m_dlon = odlon_q;
    assign m_sat  = sat_q;

endmodule

// File: tb/tb_geo_dist_operand_prep.sv
// Directed bench for geo_dist_operand_prep: single transactions with
// hand-computed operands, a stalled stream, and a mid-stream reset.
module tb_geo_dist_operand_prep;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               s_valid;
    logic               s_ready;
    logic [31:0]        lat_a, lon_a, lat_b, lon_b;
    logic               m_valid;
    logic               m_ready;
    logic [14:0]        m_coef;
    logic signed [19:0] m_dlat;
    logic signed [19:0] m_dlon;
    logic               m_sat;

    int n_cmp = 0;
    int n_err = 0;

    // Backpressure schedule, one entry per cycle.
    int exp_v  [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int exp_dl [14] = '{0, 0, 10, 10, 10, 10, 10, 10, 11, 12, 13, 14, 15, 0};
    int exp_sr [14] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

    geo_dist_operand_prep dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .lat_a    (lat_a),
        .lon_a    (lon_a),
        .lat_b    (lat_b),
        .lon_b    (lon_b),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_coef   (m_coef),
        .m_dlat   (m_dlat),
        .m_dlon   (m_dlon),
        .m_sat    (m_sat)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // One transaction, unstalled; checks exact 2-cycle latency and payload.
    task automatic run_vec(input string tag, input logic [31:0] la, input logic [31:0] oa,
                           input logic [31:0] lb, input logic [31:0] ob,
                           input int e_coef, input int e_dlat, input int e_dlon, input int e_sat);
        lat_a   = la;
        lon_a   = oa;
        lat_b   = lb;
        lon_b   = ob;
        s_valid = 1'b1;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        check({tag, "_early"}, m_valid, 0);
        step();
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_coef"}, m_coef, e_coef);
        check({tag, "_dlat"}, $signed(m_dlat), e_dlat);
        check({tag, "_dlon"}, $signed(m_dlon), e_dlon);
        check({tag, "_sat"}, m_sat, e_sat);
        step();
        check({tag, "_drain"}, m_valid, 0);
    endtask

    initial begin
        int k;
        int n_out;
        ap_rst_n = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        lat_a    = '0;
        lon_a    = '0;
        lat_b    = '0;
        lon_b    = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_coef", m_coef, 0);
        check("rst_dlat", $signed(m_dlat), 0);
        check("rst_dlon", $signed(m_dlon), 0);
        check("rst_sat", m_sat, 0);
        check("rst_sready", s_ready, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();

        // Basic scaling: 409600 / 4096 = 100.
        run_vec("basic", 32'h0, 32'h0, 32'h0, 32'd409600, 16364, 0, 100, 0);
        // Longitude wrap across +-180 deg.
        run_vec("wrap_pos", 32'h0, 32'h7FFF_F000, 32'h0, 32'h8000_1000, 16364, 0, 2, 0);
        run_vec("wrap_neg", 32'h0, 32'h8000_1000, 32'h0, 32'h7FFF_F000, 16364, 0, -2, 0);
        run_vec("floor_m1", 32'h0, 32'h1, 32'h0, 32'h0, 16364, 0, -1, 0);
        // Pole to pole clamps; mean latitude 0.
        run_vec("sat_pos", 32'hC000_0000, 32'h0, 32'h4000_0000, 32'h0, 16364, 524287, 0, 1);
        // Reverse direction lands exactly on the minimum, no clamp.
        run_vec("sat_neg", 32'h4000_0000, 32'h0, 32'hC000_0000, 32'h0, 16364, -524288, 0, 0);
        // Coefficient table edges and a middle entry.
        run_vec("coef_hi", 32'h3E00_0000, 32'h0, 32'h3E00_0000, 32'h0, 804, 0, 0, 0);
        run_vec("coef_pole", 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0, 0, 0, 0, 0);
        run_vec("coef_neg", 32'hC200_0000, 32'h0, 32'hC200_0000, 32'h0, 804, 0, 0, 0);
        // mlat = 0x20002800 -> entry 8; dlat = -0x5000 >>> 12 = -5.
        run_vec("coef_mid", 32'h2000_5000, 32'h0, 32'h2000_0000, 32'h0, 11003, -5, 0, 0);

        // Backpressure: 6 items, m_ready low for cycles 2..6.
        k     = 0;
        n_out = 0;
        for (int c = 0; c < 14; c++) begin
            m_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            if (k < 6) begin
                s_valid = 1'b1;
                lat_a   = '0;
                lat_b   = '0;
                lon_a   = '0;
                lon_b   = 32'((10 + k) * 4096);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            check($sformatf("bp_valid_c%0d", c), m_valid, exp_v[c]);
            check($sformatf("bp_sready_c%0d", c), s_ready, exp_sr[c]);
            if (exp_v[c] != 0) begin
                check($sformatf("bp_dlon_c%0d", c), $signed(m_dlon), exp_dl[c]);
            end
            if (s_valid && s_ready) k++;
            if (m_valid && m_ready) n_out++;
            step();
        end
        s_valid = 1'b0;
        check("bp_accepted", k, 6);
        check("bp_emitted", n_out, 6);

        // Mid-stream reset with two items held.
        m_ready = 1'b0;
        s_valid = 1'b1;
        lon_b   = 32'(50 * 4096);
        step();
        lon_b = 32'(51 * 4096);
        step();
        s_valid = 1'b0;
        check("mr_held_valid", m_valid, 1);
        check("mr_held_dlon", $signed(m_dlon), 50);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("mr_valid", m_valid, 0);
        check("mr_dlon", $signed(m_dlon), 0);
        check("mr_coef", m_coef, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        m_ready  = 1'b1;
        step();
        check("mr_no_stale", m_valid, 0);
        run_vec("mr_after", 32'h0, 32'h0, 32'h0, 32'(7 * 4096), 16364, 0, 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
